// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer in front of a single-ported
//            16-bit data memory. Port 0 is instruction fetch and port 1 is
//            load/store. The design supports optional wait states, registered
//            read data and a one-cycle ack for each completed access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int AW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic [1:0]    op0_i,
  input  logic [1:0]    op1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [15:0]   wdata0_i,
  input  logic [15:0]   wdata1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [15:0]   rdata0_o,
  output logic [15:0]   rdata1_o,
  output logic          busy_o,
  output logic [AW-1:0] m_addr_o,
  output logic [15:0]   m_wword_o,
  output logic [7:0]    m_wbyte_o,
  output logic [1:0]    m_memw_o,
  input  logic [15:0]   m_rword_i
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            port_q;
  logic            last_q;
  logic [3:0]      cnt_q;
  logic [1:0]      code_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     wdata_q;
  logic [1:0]      memw_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [15:0]     rdata0_q;
  logic [15:0]     rdata1_q;
  logic            busy_q;

  logic            gnt_valid_d;
  logic            gnt_port_d;
  logic [1:0]      gnt_op_d;
  logic [1:0]      gnt_code_d;

  // Grant selection: a lone requester wins; on contention the port that did
  // not win last time gets the grant. Op 11 is a read, so it strobes as 00.
  always_comb begin
    gnt_valid_d = req0_i | req1_i;
    gnt_port_d  = (req0_i && req1_i) ? ~last_q : req1_i;
    gnt_op_d    = gnt_port_d ? op1_i : op0_i;
    gnt_code_d  = (gnt_op_d == 2'b11) ? 2'b00 : gnt_op_d;
  end

  // Access sequencer: IDLE samples requests, BUSY counts wait states and
  // issues the single strobe cycle, DONE pulses the ack. All outputs are
  // registered so the strobe is set up on the edge that enters its cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      code_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 16'd0;
      memw_q   <= 2'b00;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (gnt_valid_d) begin
            port_q  <= gnt_port_d;
            last_q  <= gnt_port_d;
            addr_q  <= gnt_port_d ? addr1_i  : addr0_i;
            wdata_q <= gnt_port_d ? wdata1_i : wdata0_i;
            code_q  <= gnt_code_d;
            cnt_q   <= WS_INIT;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
            // With no wait states the first BUSY cycle is the strobe cycle.
            if (WS_INIT == 4'd0) begin
              memw_q <= gnt_code_d;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
            // Arm the strobe for the cycle in which the count reaches zero.
            if (cnt_q == 4'd1) begin
              memw_q <= code_q;
            end
          end else begin
            memw_q  <= 2'b00;
            state_q <= S_DONE;
            if (port_q) begin
              ack1_q   <= 1'b1;
              rdata1_q <= m_rword_i;
            end else begin
              ack0_q   <= 1'b1;
              rdata0_q <= m_rword_i;
            end
          end
        end
        S_DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          memw_q  <= 2'b00;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign busy_o    = busy_q;
  assign m_addr_o  = addr_q;
  assign m_wword_o = wdata_q;
  assign m_wbyte_o = wdata_q[7:0];
  assign m_memw_o  = memw_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed bench for mem_arbiter. Instance A has no wait states and
//            instance B has three. Each instance has a private 16-word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // instance A (WAIT_STATES = 0)
  logic        a_req0, a_req1;
  logic [1:0]  a_op0, a_op1;
  logic [15:0] a_addr0, a_addr1, a_wdata0, a_wdata1;
  logic        a_ack0, a_ack1, a_busy;
  logic [15:0] a_rdata0, a_rdata1, a_maddr, a_wword, a_rword;
  logic [7:0]  a_wbyte;
  logic [1:0]  a_memw;

  // instance B (WAIT_STATES = 3)
  logic        b_req0, b_req1;
  logic [1:0]  b_op0, b_op1;
  logic [15:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
  logic        b_ack0, b_ack1, b_busy;
  logic [15:0] b_rdata0, b_rdata1, b_maddr, b_wword, b_rword;
  logic [7:0]  b_wbyte;
  logic [1:0]  b_memw;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = 4'd0;
  logic [15:0] ld_data = 16'd0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_STATES(0), .AW(16)) u_a (
    .clk(clk), .rst(rst),
    .req0_i(a_req0), .req1_i(a_req1), .op0_i(a_op0), .op1_i(a_op1),
    .addr0_i(a_addr0), .addr1_i(a_addr1), .wdata0_i(a_wdata0), .wdata1_i(a_wdata1),
    .ack0_o(a_ack0), .ack1_o(a_ack1), .rdata0_o(a_rdata0), .rdata1_o(a_rdata1),
    .busy_o(a_busy), .m_addr_o(a_maddr), .m_wword_o(a_wword), .m_wbyte_o(a_wbyte),
    .m_memw_o(a_memw), .m_rword_i(a_rword)
  );

  mem_arbiter #(.WAIT_STATES(3), .AW(16)) u_b (
    .clk(clk), .rst(rst),
    .req0_i(b_req0), .req1_i(b_req1), .op0_i(b_op0), .op1_i(b_op1),
    .addr0_i(b_addr0), .addr1_i(b_addr1), .wdata0_i(b_wdata0), .wdata1_i(b_wdata1),
    .ack0_o(b_ack0), .ack1_o(b_ack1), .rdata0_o(b_rdata0), .rdata1_o(b_rdata1),
    .busy_o(b_busy), .m_addr_o(b_maddr), .m_wword_o(b_wword), .m_wbyte_o(b_wbyte),
    .m_memw_o(b_memw), .m_rword_i(b_rword)
  );

  // Memories: combinational read, synchronous word / low-byte write.
  assign a_rword = mem_a[a_maddr[3:0]];
  assign b_rword = mem_b[b_maddr[3:0]];

  always @(posedge clk) begin
    if (ld_en) begin
      mem_a[ld_addr] <= ld_data;
      mem_b[ld_addr] <= ld_data;
    end else begin
      if (a_memw == 2'b10)      mem_a[a_maddr[3:0]]      <= a_wword;
      else if (a_memw == 2'b01) mem_a[a_maddr[3:0]][7:0] <= a_wbyte;
      if (b_memw == 2'b10)      mem_b[b_maddr[3:0]]      <= b_wword;
      else if (b_memw == 2'b01) mem_b[b_maddr[3:0]][7:0] <= b_wbyte;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] adr, input logic [15:0] dat);
    ld_en   = 1'b1;
    ld_addr = adr;
    ld_data = dat;
    tick();
    ld_en   = 1'b0;
  endtask

  initial begin
    a_req0 = 0; a_req1 = 0; a_op0 = 0; a_op1 = 0;
    a_addr0 = 0; a_addr1 = 0; a_wdata0 = 0; a_wdata1 = 0;
    b_req0 = 0; b_req1 = 0; b_op0 = 0; b_op1 = 0;
    b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;

    // Clear both memories, then preload known words while in reset.
    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
    preload(4'd3, 16'hBEEF);
    preload(4'd2, 16'h5566);

    // Reset state
    chk("rst_ack0",  32'(a_ack0),   32'h0);
    chk("rst_ack1",  32'(a_ack1),   32'h0);
    chk("rst_busy",  32'(a_busy),   32'h0);
    chk("rst_memw",  32'(a_memw),   32'h0);
    chk("rst_maddr", 32'(a_maddr),  32'h0);
    chk("rst_rdata0",32'(a_rdata0), 32'h0);
    chk("rst_b_busy",32'(b_busy),   32'h0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(a_busy), 32'h0);

    // Read addr 3 on port 0, no wait states
    a_req0 = 1; a_op0 = 2'b00; a_addr0 = 16'd3;
    tick();
    chk("t1_busy",   32'(a_busy),  32'h1);
    chk("t1_memw",   32'(a_memw),  32'h0);
    chk("t1_maddr",  32'(a_maddr), 32'h3);
    chk("t1_ack0_e", 32'(a_ack0),  32'h0);
    tick();
    chk("t1_ack0",   32'(a_ack0),   32'h1);
    chk("t1_ack1",   32'(a_ack1),   32'h0);
    chk("t1_rdata0", 32'(a_rdata0), 32'hBEEF);
    chk("t1_memw_d", 32'(a_memw),   32'h0);
    a_req0 = 0;
    tick();
    chk("t1_ack0_off", 32'(a_ack0), 32'h0);
    chk("t1_idle",     32'(a_busy), 32'h0);
    chk("t1_ack1_n",   32'(a_ack1), 32'h0);

    // Word write 1234 to addr 5 on port 1
    a_req1 = 1; a_op1 = 2'b10; a_addr1 = 16'd5; a_wdata1 = 16'h1234;
    tick();
    chk("t2_memw",  32'(a_memw),  32'h2);
    chk("t2_maddr", 32'(a_maddr), 32'h5);
    chk("t2_wword", 32'(a_wword), 32'h1234);
    tick();
    chk("t2_memw_d", 32'(a_memw), 32'h0);
    chk("t2_ack1",   32'(a_ack1), 32'h1);
    chk("t2_ack0",   32'(a_ack0), 32'h0);
    a_req1 = 0;
    tick();
    // Read it back through port 0
    a_req0 = 1; a_op0 = 2'b00; a_addr0 = 16'd5;
    tick();
    tick();
    chk("t2_rb_ack0",  32'(a_ack0),   32'h1);
    chk("t2_rb_rdata", 32'(a_rdata0), 32'h1234);
    a_req0 = 0;
    tick();

    // Op 11 on port 1 is a read
    a_req1 = 1; a_op1 = 2'b11; a_addr1 = 16'd3;
    tick();
    chk("t6_memw", 32'(a_memw), 32'h0);
    chk("t6_busy", 32'(a_busy), 32'h1);
    tick();
    chk("t6_ack1",   32'(a_ack1),   32'h1);
    chk("t6_rdata1", 32'(a_rdata1), 32'hBEEF);
    chk("t6_memw_d", 32'(a_memw),   32'h0);
    a_req1 = 0;
    tick();
    chk("t6_mem3", 32'(mem_a[3]), 32'hBEEF);

    // Both ports requesting continuously from reset: 0,1,0,1
    rst = 0;
    tick();
    rst = 1;
    a_req0 = 1; a_op0 = 2'b00; a_addr0 = 16'd3;
    a_req1 = 1; a_op1 = 2'b00; a_addr1 = 16'd5;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_busy", 32'(a_busy), 32'h1);
      chk("t3_pre_ack", 32'({a_ack1, a_ack0}), 32'h0);
      tick();
      chk("t3_ack0", 32'(a_ack0), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("t3_ack1", 32'(a_ack1), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k % 2 == 0) chk("t3_rdata0", 32'(a_rdata0), 32'hBEEF);
      else            chk("t3_rdata1", 32'(a_rdata1), 32'h1234);
      tick();
      chk("t3_idle", 32'(a_busy), 32'h0);
    end
    a_req0 = 0; a_req1 = 0;
    tick();

    // Three wait states, byte write AA to addr 2 (mem[2] = 5566)
    b_req0 = 1; b_op0 = 2'b01; b_addr0 = 16'd2; b_wdata0 = 16'h77AA;
    tick();
    chk("t4_busy", 32'(b_busy), 32'h1);
    chk("t4_memw_0", 32'(b_memw), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t4_memw", 32'(b_memw), (i == 3) ? 32'h1 : 32'h0);
      chk("t4_noack", 32'(b_ack0), 32'h0);
    end
    chk("t4_maddr", 32'(b_maddr), 32'h2);
    chk("t4_wbyte", 32'(b_wbyte), 32'hAA);
    tick();
    chk("t4_ack0",   32'(b_ack0), 32'h1);
    chk("t4_memw_d", 32'(b_memw), 32'h0);
    b_req0 = 0;
    tick();
    chk("t4_mem2", 32'(mem_b[2]), 32'h55AA);

    // Reset during BUSY before the strobe aborts the write
    b_req1 = 1; b_op1 = 2'b10; b_addr1 = 16'd2; b_wdata1 = 16'hDEAD;
    tick();
    tick();
    chk("t5_busy_pre", 32'(b_busy), 32'h1);
    b_req1 = 0;
    rst = 0;
    #1;
    chk("t5_memw",   32'(b_memw),   32'h0);
    chk("t5_busy",   32'(b_busy),   32'h0);
    chk("t5_maddr",  32'(b_maddr),  32'h0);
    chk("t5_wword",  32'(b_wword),  32'h0);
    chk("t5_rdata0", 32'(b_rdata0), 32'h0);
    tick();
    tick();
    chk("t5_ack1", 32'(b_ack1), 32'h0);
    rst = 1;
    tick();
    chk("t5_ack1_after", 32'(b_ack1), 32'h0);
    chk("t5_mem2", 32'(mem_b[2]), 32'h55AA);
    // Read back through the arbiter: grant + 3 waits + strobe, then ack
    b_req0 = 1; b_op0 = 2'b00; b_addr0 = 16'd2;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_rb_ack0",  32'(b_ack0),   32'h1);
    chk("t5_rb_rdata", 32'(b_rdata0), 32'h55AA);
    b_req0 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
